// File: rtl/sr_pq_gen_if.sv
// Request/response bundle of the sr_pq_gen shift-register priority queue.
// The master drives enqueue/dequeue requests; the slave (the queue) returns head and status.
interface sr_pq_gen_if #(
    parameter int KEY_W = 8,
    parameter int VAL_W = 8,
    parameter int DEPTH = 8
);
    logic                         enq;
    logic                         deq;
    logic [KEY_W-1:0]             kvi_key;
    logic [VAL_W-1:0]             kvi_val;
    logic [KEY_W-1:0]             kvo_key;
    logic [VAL_W-1:0]             kvo_val;
    logic                         kvo_valid;
    logic                         full;
    logic                         empty;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         ovf;
    logic                         udf;

    modport master (
        output enq, deq, kvi_key, kvi_val,
        input  kvo_key, kvo_val, kvo_valid, full, empty, count, ovf, udf
    );

    modport slave (
        input  enq, deq, kvi_key, kvi_val,
        output kvo_key, kvo_val, kvo_valid, full, empty, count, ovf, udf
    );
endinterface

// File: rtl/sr_pq_gen.sv
// Parametrised shift-register priority queue with replace, FIFO tie order and occupancy flags.
// Optional high-water-mark output enabled by defining SR_PQ_HWM_EN.
module sr_pq_gen #(
    parameter int KEY_W    = 8,
    parameter int VAL_W    = 8,
    parameter int DEPTH    = 8,
    parameter int MIN_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    sr_pq_gen_if.slave                 bus
`ifdef SR_PQ_HWM_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] hwm
`endif
);

    localparam int CW = $clog2(DEPTH+1);
    typedef logic [CW-1:0] cnt_t;

    logic             vld_q [DEPTH];
    logic [KEY_W-1:0] key_q [DEPTH];
    logic [VAL_W-1:0] val_q [DEPTH];
    logic             vld_d [DEPTH];
    logic [KEY_W-1:0] key_d [DEPTH];
    logic [VAL_W-1:0] val_d [DEPTH];

    cnt_t count_q, count_d;
    logic full_q, full_d;
    logic empty_q, empty_d;
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    function automatic logic key_wins(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
        if (MIN_MODE != 0) return a < b;
        else               return a > b;
    endfunction

    // Cells viewed one slot toward the head, i.e. the queue after a pop.
    logic             lv   [DEPTH];
    logic [KEY_W-1:0] lk   [DEPTH];
    logic [VAL_W-1:0] lval [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            lv[i]   = vld_q[i+1];
            lk[i]   = key_q[i+1];
            lval[i] = val_q[i+1];
        end
        lv[DEPTH-1]   = 1'b0;
        lk[DEPTH-1]   = '0;
        lval[DEPTH-1] = '0;
    end

    // nb: new entry beats the stored cell; le: popped-view cell beats or ties the new entry.
    logic nb [DEPTH];
    logic le [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            nb[i] = !vld_q[i] || key_wins(bus.kvi_key, key_q[i]);
            le[i] = lv[i] && !key_wins(bus.kvi_key, lk[i]);
        end
    end

    logic             ins_v [DEPTH];
    logic [KEY_W-1:0] ins_k [DEPTH];
    logic [VAL_W-1:0] ins_x [DEPTH];

    always_comb begin
        if (nb[0]) begin
            ins_v[0] = 1'b1;
            ins_k[0] = bus.kvi_key;
            ins_x[0] = bus.kvi_val;
        end else begin
            ins_v[0] = vld_q[0];
            ins_k[0] = key_q[0];
            ins_x[0] = val_q[0];
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (nb[i] && !nb[i-1]) begin
                ins_v[i] = 1'b1;
                ins_k[i] = bus.kvi_key;
                ins_x[i] = bus.kvi_val;
            end else if (nb[i-1]) begin
                ins_v[i] = vld_q[i-1];
                ins_k[i] = key_q[i-1];
                ins_x[i] = val_q[i-1];
            end else begin
                ins_v[i] = vld_q[i];
                ins_k[i] = key_q[i];
                ins_x[i] = val_q[i];
            end
        end
    end

    logic             rep_v [DEPTH];
    logic [KEY_W-1:0] rep_k [DEPTH];
    logic [VAL_W-1:0] rep_x [DEPTH];

    always_comb begin
        if (le[0]) begin
            rep_v[0] = lv[0];
            rep_k[0] = lk[0];
            rep_x[0] = lval[0];
        end else begin
            rep_v[0] = 1'b1;
            rep_k[0] = bus.kvi_key;
            rep_x[0] = bus.kvi_val;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (le[i]) begin
                rep_v[i] = lv[i];
                rep_k[i] = lk[i];
                rep_x[i] = lval[i];
            end else if (le[i-1]) begin
                rep_v[i] = 1'b1;
                rep_k[i] = bus.kvi_key;
                rep_x[i] = bus.kvi_val;
            end else begin
                rep_v[i] = lv[i-1];
                rep_k[i] = lk[i-1];
                rep_x[i] = lval[i-1];
            end
        end
    end

    always_comb begin
        vld_d   = vld_q;
        key_d   = key_q;
        val_d   = val_q;
        count_d = count_q;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
        unique case ({bus.enq, bus.deq})
            2'b10: begin
                if (full_q) begin
                    ovf_d = 1'b1;
                end else begin
                    vld_d   = ins_v;
                    key_d   = ins_k;
                    val_d   = ins_x;
                    count_d = count_q + cnt_t'(1);
                end
            end
            2'b01: begin
                if (empty_q) begin
                    udf_d = 1'b1;
                end else begin
                    vld_d   = lv;
                    key_d   = lk;
                    val_d   = lval;
                    count_d = count_q - cnt_t'(1);
                end
            end
            2'b11: begin
                // Replace on an empty queue degenerates to a plain insert.
                if (empty_q) begin
                    vld_d   = ins_v;
                    key_d   = ins_k;
                    val_d   = ins_x;
                    count_d = cnt_t'(1);
                    udf_d   = 1'b1;
                end else begin
                    vld_d = rep_v;
                    key_d = rep_k;
                    val_d = rep_x;
                end
            end
            default: ;
        endcase
        full_d  = (count_d == cnt_t'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i] <= 1'b0;
                key_q[i] <= '0;
                val_q[i] <= '0;
            end
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            key_q   <= key_d;
            val_q   <= val_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

`ifdef SR_PQ_HWM_EN
    cnt_t hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (count_q > hwm_q) hwm_d = count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) hwm_q <= '0;
        else     hwm_q <= hwm_d;
    end

    assign hwm = hwm_q;
`endif

    assign bus.kvo_valid = vld_q[0];
    assign bus.kvo_key   = key_q[0];
    assign bus.kvo_val   = val_q[0];
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.count     = count_q;
    assign bus.ovf       = ovf_q;
    assign bus.udf       = udf_q;

endmodule

// File: tb/tb_sr_pq_gen.sv
// Bench for sr_pq_gen: two DEPTH=4 queues (max-first and min-first) checked against a sorted-list model.
module tb_sr_pq_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sr_pq_gen_if #(.KEY_W(8), .VAL_W(8), .DEPTH(4)) if0 ();
    sr_pq_gen_if #(.KEY_W(8), .VAL_W(8), .DEPTH(4)) if1 ();

    logic [2:0] h0, h1;

`ifdef SR_PQ_HWM_EN
    sr_pq_gen #(.KEY_W(8), .VAL_W(8), .DEPTH(4), .MIN_MODE(0)) u0 (.clk(clk), .rst(rst), .bus(if0), .hwm(h0));
    sr_pq_gen #(.KEY_W(8), .VAL_W(8), .DEPTH(4), .MIN_MODE(1)) u1 (.clk(clk), .rst(rst), .bus(if1), .hwm(h1));
`else
    sr_pq_gen #(.KEY_W(8), .VAL_W(8), .DEPTH(4), .MIN_MODE(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
    sr_pq_gen #(.KEY_W(8), .VAL_W(8), .DEPTH(4), .MIN_MODE(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    assign h0 = 3'd0;
    assign h1 = 3'd0;
`endif

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    // Model: per instance a sorted list (index 0 = head) plus flags.
    logic [7:0] mk [2][4];
    logic [7:0] mv [2][4];
    int         mcnt [2];
    int         mhwm [2];
    bit         movf [2];
    bit         mudf [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit wins(input int inst, input logic [7:0] a, input logic [7:0] b);
        return (inst == 1) ? (a < b) : (a > b);
    endfunction

    task automatic m_insert(input int inst, input logic [7:0] k, input logic [7:0] v);
        int  pos;
        bit  found;
        pos   = mcnt[inst];
        found = 1'b0;
        for (int p = 0; p < 4; p++)
            if (!found && p < mcnt[inst] && wins(inst, k, mk[inst][p])) begin
                pos   = p;
                found = 1'b1;
            end
        for (int p = 3; p > 0; p--)
            if (p > pos) begin
                mk[inst][p] = mk[inst][p-1];
                mv[inst][p] = mv[inst][p-1];
            end
        mk[inst][pos] = k;
        mv[inst][pos] = v;
        mcnt[inst]++;
    endtask

    task automatic m_pop(input int inst);
        for (int p = 0; p < 3; p++) begin
            mk[inst][p] = mk[inst][p+1];
            mv[inst][p] = mv[inst][p+1];
        end
        mk[inst][3] = 8'h00;
        mv[inst][3] = 8'h00;
        mcnt[inst]--;
    endtask

    task automatic m_step(input int inst, input bit r, input bit e, input bit d,
                          input logic [7:0] k, input logic [7:0] v);
        if (r) begin
            mcnt[inst] = 0;
            mhwm[inst] = 0;
            movf[inst] = 1'b0;
            mudf[inst] = 1'b0;
            for (int p = 0; p < 4; p++) begin
                mk[inst][p] = 8'h00;
                mv[inst][p] = 8'h00;
            end
        end else begin
            if (mcnt[inst] > mhwm[inst]) mhwm[inst] = mcnt[inst];
            movf[inst] = 1'b0;
            mudf[inst] = 1'b0;
            if (e && !d) begin
                if (mcnt[inst] == 4) movf[inst] = 1'b1;
                else                 m_insert(inst, k, v);
            end else if (!e && d) begin
                if (mcnt[inst] == 0) mudf[inst] = 1'b1;
                else                 m_pop(inst);
            end else if (e && d) begin
                if (mcnt[inst] == 0) mudf[inst] = 1'b1;
                else                 m_pop(inst);
                m_insert(inst, k, v);
            end
        end
    endtask

    // One clock: inputs applied at negedge, model advanced at the posedge, returns 1 ns later.
    task automatic step(input int inst, input bit r, input bit e, input bit d,
                        input logic [7:0] k, input logic [7:0] v);
        @(negedge clk);
        rst         = r;
        if0.enq     = (inst == 0) && e;
        if0.deq     = (inst == 0) && d;
        if0.kvi_key = k;
        if0.kvi_val = v;
        if1.enq     = (inst == 1) && e;
        if1.deq     = (inst == 1) && d;
        if1.kvi_key = k;
        if1.kvi_val = v;
        @(posedge clk);
        m_step(0, r, (inst == 0) && e, (inst == 0) && d, k, v);
        m_step(1, r, (inst == 1) && e, (inst == 1) && d, k, v);
        #1;
    endtask

    task automatic cmp(input int inst, input logic vld, input logic [7:0] k, input logic [7:0] v,
                       input logic [2:0] cnt, input logic fl, input logic em,
                       input logic ov, input logic ud, input logic [2:0] hw);
        string s;
        s = $sformatf("u%0d", inst);
        chk({s, ".kvo_valid"}, vld, mcnt[inst] > 0);
        chk({s, ".count"}, cnt, mcnt[inst]);
        chk({s, ".full"}, fl, mcnt[inst] == 4);
        chk({s, ".empty"}, em, mcnt[inst] == 0);
        chk({s, ".ovf"}, ov, movf[inst]);
        chk({s, ".udf"}, ud, mudf[inst]);
        if (mcnt[inst] > 0) begin
            chk({s, ".kvo_key"}, k, mk[inst][0]);
            chk({s, ".kvo_val"}, v, mv[inst][0]);
        end
`ifdef SR_PQ_HWM_EN
        chk({s, ".hwm"}, hw, mhwm[inst]);
`else
        if (hw !== 3'd0) chk({s, ".hwm_tie"}, hw, 0);
`endif
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            cmp(0, if0.kvo_valid, if0.kvo_key, if0.kvo_val, if0.count, if0.full, if0.empty,
                if0.ovf, if0.udf, h0);
            cmp(1, if1.kvo_valid, if1.kvo_key, if1.kvo_val, if1.count, if1.full, if1.empty,
                if1.ovf, if1.udf, h1);
        end
    end

    initial begin
        if0.enq = 0; if0.deq = 0; if0.kvi_key = 0; if0.kvi_val = 0;
        if1.enq = 0; if1.deq = 0; if1.kvi_key = 0; if1.kvi_val = 0;

        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("rst.empty", if0.empty, 1);
        chk("rst.count", if0.count, 0);
        chk("rst.kvo_valid", if0.kvo_valid, 0);
        chk("rst.kvo_key", if0.kvo_key, 0);
        chk("rst.kvo_val", if0.kvo_val, 0);
        chk("rst.full", if0.full, 0);
        mon_en = 1'b1;

        // Max-first fill: 5,9,2,7
        step(0, 0, 1, 0, 8'd5, 8'h50);
        step(0, 0, 1, 0, 8'd9, 8'h90);
        step(0, 0, 1, 0, 8'd2, 8'h20);
        step(0, 0, 1, 0, 8'd7, 8'h70);
        chk("fill.full", if0.full, 1);
        chk("fill.count", if0.count, 4);
        chk("fill.head", if0.kvo_key, 9);

        step(0, 0, 1, 0, 8'd8, 8'h80);
        chk("ovf.pulse", if0.ovf, 1);
        chk("ovf.head", if0.kvo_key, 9);
        chk("ovf.count", if0.count, 4);
        step(0, 0, 0, 0, 0, 0);
        chk("ovf.clear", if0.ovf, 0);

        step(0, 0, 0, 1, 0, 0);
        chk("deq1.head", if0.kvo_key, 7);
        step(0, 0, 0, 1, 0, 0);
        chk("deq2.head", if0.kvo_key, 5);
        step(0, 0, 0, 1, 0, 0);
        chk("deq3.head", if0.kvo_key, 2);
        chk("deq3.val", if0.kvo_val, 8'h20);
        step(0, 0, 0, 1, 0, 0);
        chk("deq4.empty", if0.empty, 1);

        step(0, 0, 0, 1, 0, 0);
        chk("udf.pulse", if0.udf, 1);
        chk("udf.valid", if0.kvo_valid, 0);
        chk("udf.count", if0.count, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("udf.clear", if0.udf, 0);

        // Replace on {9,7,5} then on a full queue
        step(0, 0, 1, 0, 8'd9, 8'h91);
        step(0, 0, 1, 0, 8'd7, 8'h71);
        step(0, 0, 1, 0, 8'd5, 8'h51);
        step(0, 0, 1, 1, 8'd6, 8'h61);
        chk("rep.head", if0.kvo_key, 7);
        chk("rep.count", if0.count, 3);
        step(0, 0, 1, 0, 8'd3, 8'h31);
        step(0, 0, 1, 1, 8'd1, 8'h11);
        chk("repfull.head", if0.kvo_key, 6);
        chk("repfull.count", if0.count, 4);
        chk("repfull.ovf", if0.ovf, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("repfull.d1", if0.kvo_key, 5);
        step(0, 0, 0, 1, 0, 0);
        chk("repfull.d2", if0.kvo_key, 3);
        step(0, 0, 0, 1, 0, 0);
        chk("repfull.tail", if0.kvo_key, 1);
        step(0, 0, 0, 1, 0, 0);

        // FIFO order among equal keys
        step(0, 0, 1, 0, 8'd4, 8'hAA);
        step(0, 0, 1, 0, 8'd4, 8'hBB);
        chk("tie.first", if0.kvo_val, 8'hAA);
        step(0, 0, 0, 1, 0, 0);
        chk("tie.second", if0.kvo_val, 8'hBB);
        step(0, 0, 0, 1, 0, 0);

        // Replace with a key equal to the survivor: survivor stays ahead
        step(0, 0, 1, 0, 8'd7, 8'h77);
        step(0, 0, 1, 0, 8'd4, 8'hA4);
        step(0, 0, 1, 1, 8'd4, 8'hC4);
        chk("reptie.first", if0.kvo_val, 8'hA4);
        step(0, 0, 0, 1, 0, 0);
        chk("reptie.second", if0.kvo_val, 8'hC4);
        step(0, 0, 0, 1, 0, 0);

        // Replace while empty behaves as insert with udf
        step(0, 0, 1, 1, 8'd3, 8'h33);
        chk("repempty.udf", if0.udf, 1);
        chk("repempty.count", if0.count, 1);
        chk("repempty.head", if0.kvo_key, 3);
        step(0, 0, 0, 1, 0, 0);

        // Min-first: 5,9,2
        step(1, 0, 1, 0, 8'd5, 8'h05);
        step(1, 0, 1, 0, 8'd9, 8'h09);
        step(1, 0, 1, 0, 8'd2, 8'h02);
        chk("min.head", if1.kvo_key, 2);
        step(1, 0, 0, 1, 0, 0);
        chk("min.d1", if1.kvo_key, 5);
        step(1, 0, 0, 1, 0, 0);
        chk("min.d2", if1.kvo_key, 9);
        step(1, 0, 0, 1, 0, 0);
        chk("min.empty", if1.empty, 1);

        // Min-first full, overflow, then replace removes the smallest
        step(1, 0, 1, 0, 8'd5, 8'h05);
        step(1, 0, 1, 0, 8'd9, 8'h09);
        step(1, 0, 1, 0, 8'd2, 8'h02);
        step(1, 0, 1, 0, 8'd7, 8'h07);
        step(1, 0, 1, 0, 8'd1, 8'h01);
        chk("min.ovf", if1.ovf, 1);
        chk("min.ovfhead", if1.kvo_key, 2);
        step(1, 0, 1, 1, 8'd8, 8'h08);
        chk("min.rephead", if1.kvo_key, 5);

        // Mixed traffic with narrow keys to exercise ties
        for (int n = 0; n < 300; n++) begin
            int          inst;
            bit          e, d;
            logic [7:0]  k, v;
            inst = n % 2;
            e    = ($urandom_range(0, 99) < 55);
            d    = ($urandom_range(0, 99) < 45);
            k    = 8'($urandom_range(0, 5));
            if ((n % 37) == 0) k = 8'hFF;
            v    = 8'(n);
            step(inst, 0, e, d, k, v);
        end

        // Reset mid-stream wins over a simultaneous enqueue
        step(0, 0, 1, 0, 8'd1, 8'h01);
        step(0, 0, 1, 0, 8'd2, 8'h02);
        step(0, 1, 1, 0, 8'd3, 8'h03);
        chk("midrst.empty", if0.empty, 1);
        chk("midrst.count", if0.count, 0);
        chk("midrst.valid", if0.kvo_valid, 0);
`ifdef SR_PQ_HWM_EN
        chk("midrst.hwm", h0, 0);
`endif
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
